// File: rtl/tanh_deriv_pkg.sv
// Shared constants and word layouts for the tanh-derivative pipeline.
// Input words are 1/5/6 (bias 15); output words are 1/6/12 (bias 31).
package tanh_deriv_pkg;

    localparam int unsigned IN_BIAS        = 15;
    localparam int unsigned OUT_BIAS       = 31;
    localparam int unsigned IN_EXP_W       = 5;
    localparam int unsigned IN_MAN_W       = 6;
    localparam int unsigned OUT_EXP_W      = 6;
    localparam int unsigned OUT_MAN_W      = 12;
    localparam int unsigned FRAC_W_DEFAULT = 24;
    localparam int unsigned SIG_W          = IN_MAN_W + 1;
    localparam int unsigned SQ_W           = 2 * SIG_W;

    typedef struct packed {
        logic                 sign;
        logic [IN_EXP_W-1:0]  exponent;
        logic [IN_MAN_W-1:0]  mantissa;
    } in_word_t;

    typedef struct packed {
        logic                 sign;
        logic [OUT_EXP_W-1:0] exponent;
        logic [OUT_MAN_W-1:0] mantissa;
    } out_word_t;

    localparam out_word_t ZERO_OUT = '0;
    localparam out_word_t ONE_OUT  = out_word_t'({1'b0, OUT_EXP_W'(OUT_BIAS), OUT_MAN_W'(0)});

endpackage

// File: rtl/tanh_deriv_if.sv
// Valid/ready stream bus carrying the activation word in and the derivative word out.
interface tanh_deriv_if;
    import tanh_deriv_pkg::*;

    logic                 ValidIn;
    logic                 ReadyOut;
    logic                 Sign;
    logic [IN_EXP_W-1:0]  Exponent;
    logic [IN_MAN_W-1:0]  Mantissa;
    logic                 ValidOut;
    logic                 ReadyIn;
    logic                 SignOut;
    logic [OUT_EXP_W-1:0] ExponentOut;
    logic [OUT_MAN_W-1:0] MantissaOut;

    modport master (
        output ValidIn, Sign, Exponent, Mantissa, ReadyIn,
        input  ReadyOut, ValidOut, SignOut, ExponentOut, MantissaOut
    );

    modport slave (
        input  ValidIn, Sign, Exponent, Mantissa, ReadyIn,
        output ReadyOut, ValidOut, SignOut, ExponentOut, MantissaOut
    );

endinterface

// File: rtl/tanh_deriv_lzc_frac.sv
// Combinational leading-zero counter over a fraction; all-zero input reports W.
module lzc_frac #(
    parameter  int unsigned W     = 24,
    localparam int unsigned CNT_W = $clog2(W + 1)
) (
    input  logic [W-1:0]     value,
    output logic [CNT_W-1:0] count_c
);

    // Scan upward so the highest set bit has the final say.
    always_comb begin
        count_c = CNT_W'(W);
        for (int i = 0; i < W; i++) begin
            if (value[i]) count_c = CNT_W'(W - 1 - i);
        end
    end

endmodule

// File: rtl/tanh_deriv.sv
// Three-stage pipeline computing d = 1 - y^2 (square, subtract, normalize/pack)
// with a single global advance enable driven by downstream backpressure.
module tanh_deriv
    import tanh_deriv_pkg::*;
#(
    parameter int unsigned FRAC_W = FRAC_W_DEFAULT
) (
    input  logic          Clock,
    input  logic          Reset,
    tanh_deriv_if.slave   bus
);

    localparam int unsigned FIX_W  = FRAC_W + 1;
    localparam int unsigned PROD_W = SQ_W + FRAC_W;
    localparam int unsigned CNT_W  = $clog2(FRAC_W + 1);
    localparam logic [FIX_W-1:0] ONE_FIX = FIX_W'(1) << FRAC_W;

    logic               en;
    logic               in_zero;
    logic               in_clamp;
    logic [SIG_W-1:0]   sig;
    logic [SQ_W-1:0]    sq;
    logic [5:0]         rsh;
    logic [FIX_W-1:0]   y2_c;
    logic               v1;
    logic [FIX_W-1:0]   y2_q;
    logic               v2;
    logic [FIX_W-1:0]   d_q;
    logic [FRAC_W-1:0]  frac;
    logic [CNT_W-1:0]   lz_c;
    out_word_t          pack_c;
    logic               sign_unused;

    assign en           = bus.ReadyIn | ~bus.ValidOut;
    assign bus.ReadyOut = en;
    assign sign_unused  = bus.Sign;

    // S1: y^2 in fixed point; the significand square carries 2*IN_MAN_W fraction bits.
    always_comb begin
        in_zero  = (bus.Exponent == '0) && (bus.Mantissa == '0);
        in_clamp = (bus.Exponent > IN_EXP_W'(IN_BIAS)) ||
                   ((bus.Exponent == IN_EXP_W'(IN_BIAS)) && (bus.Mantissa != '0));
        sig      = {1'b1, bus.Mantissa};
        sq       = SQ_W'(sig) * SQ_W'(sig);
        rsh      = 6'(2 * IN_MAN_W + 2 * IN_BIAS) - {bus.Exponent, 1'b0};
        y2_c     = FIX_W'((PROD_W'(sq) << FRAC_W) >> rsh);
        if (in_zero)       y2_c = '0;
        else if (in_clamp) y2_c = ONE_FIX;
    end

    assign frac = d_q[FRAC_W-1:0];

    lzc_frac #(.W(FRAC_W)) u_lzc (
        .value   (frac),
        .count_c (lz_c)
    );

    // S3: exponent from the leading-one position, mantissa from the bits just below it.
    always_comb begin
        pack_c = ZERO_OUT;
        if (d_q[FRAC_W]) begin
            pack_c = ONE_OUT;
        end else if (frac != '0) begin
            pack_c.exponent = OUT_EXP_W'(OUT_BIAS) - OUT_EXP_W'(lz_c) - OUT_EXP_W'(1);
            pack_c.mantissa = OUT_MAN_W'((frac << (32'(lz_c) + 32'd1)) >> (FRAC_W - OUT_MAN_W));
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            v1              <= 1'b0;
            y2_q            <= '0;
            v2              <= 1'b0;
            d_q             <= '0;
            bus.ValidOut    <= 1'b0;
            bus.SignOut     <= 1'b0;
            bus.ExponentOut <= '0;
            bus.MantissaOut <= '0;
        end else if (en) begin
            v1              <= bus.ValidIn;
            y2_q            <= y2_c;
            v2              <= v1;
            d_q             <= ONE_FIX - y2_q;
            bus.ValidOut    <= v2;
            bus.SignOut     <= pack_c.sign;
            bus.ExponentOut <= pack_c.exponent;
            bus.MantissaOut <= pack_c.mantissa;
        end
    end

endmodule

// File: tb/tb_tanh_deriv.sv
// Directed bench for tanh_deriv: vector table, backpressure stream and mid-flight reset.
module tb_tanh_deriv;
    import tanh_deriv_pkg::*;

    typedef struct {
        logic        sign;
        logic [4:0]  e;
        logic [5:0]  m;
        logic [5:0]  xe;
        logic [11:0] xm;
        string       name;
    } vec_t;

    logic Clock = 1'b0;
    logic Reset;
    int   n_vec = 0;
    int   n_bad = 0;
    vec_t vecs[12];

    tanh_deriv_if bus();

    tanh_deriv #(.FRAC_W(24)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic drive(input logic v, input vec_t w);
        bus.ValidIn  = v;
        bus.Sign     = w.sign;
        bus.Exponent = w.e;
        bus.Mantissa = w.m;
    endtask

    function automatic logic [19:0] out_now();
        return {bus.ValidOut, bus.SignOut, bus.ExponentOut, bus.MantissaOut};
    endfunction

    function automatic logic [19:0] out_exp(input vec_t w);
        return {1'b1, 1'b0, w.xe, w.xm};
    endfunction

    initial begin
        vec_t        words[4];
        vec_t        q[$];
        vec_t        got;
        int          sent;
        int          stall;
        bit          stalled_prev;
        logic [19:0] snap;
        int          first;
        int          seen;

        vecs[0]  = '{1'b0, 5'd14, 6'h00, 6'd30, 12'h800, "half"};
        vecs[1]  = '{1'b1, 5'd14, 6'h20, 6'd29, 12'hC00, "neg_0p75"};
        vecs[2]  = '{1'b0, 5'd0,  6'h00, 6'd31, 12'h000, "zero"};
        vecs[3]  = '{1'b1, 5'd15, 6'h00, 6'd0,  12'h000, "neg_one"};
        vecs[4]  = '{1'b1, 5'd16, 6'h00, 6'd0,  12'h000, "clamp_e16"};
        vecs[5]  = '{1'b0, 5'd1,  6'h00, 6'd31, 12'h000, "tiny_trunc"};
        vecs[6]  = '{1'b0, 5'd13, 6'h00, 6'd30, 12'hE00, "quarter"};
        vecs[7]  = '{1'b0, 5'd14, 6'h30, 6'd28, 12'hE00, "p0875"};
        vecs[8]  = '{1'b0, 5'd14, 6'h01, 6'd30, 12'h7BF, "half_lsb"};
        vecs[9]  = '{1'b0, 5'd9,  6'h00, 6'd30, 12'hFFE, "pow_m6"};
        vecs[10] = '{1'b0, 5'd15, 6'h01, 6'd0,  12'h000, "clamp_e15"};
        vecs[11] = '{1'b0, 5'd31, 6'h3F, 6'd0,  12'h000, "clamp_max"};

        // Reset state, with a word offered during reset that must be dropped.
        Reset       = 1'b0;
        bus.ReadyIn = 1'b0;
        drive(1'b1, vecs[0]);
        @(negedge Clock);
        tick();
        tick();
        check("reset_out", 32'(out_now()), 32'd0);
        check("reset_ready", 32'(bus.ReadyOut), 32'd1);
        drive(1'b0, vecs[0]);
        Reset       = 1'b1;
        bus.ReadyIn = 1'b1;
        repeat (4) tick();
        check("reset_drop", 32'(bus.ValidOut), 32'd0);

        // Table: each word alone, exact 3-cycle latency.
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, vecs[i]);
            tick();
            drive(1'b0, vecs[i]);
            tick();
            check({vecs[i].name, "_latency"}, 32'(bus.ValidOut), 32'd0);
            tick();
            check(vecs[i].name, 32'(out_now()), 32'(out_exp(vecs[i])));
        end
        tick();

        // Back-to-back stream with a 2-cycle downstream stall once output appears.
        words[0] = vecs[0];
        words[1] = vecs[1];
        words[2] = vecs[6];
        words[3] = vecs[8];
        sent         = 0;
        stall        = -1;
        stalled_prev = 1'b0;
        snap         = '0;
        for (int cyc = 0; cyc < 40 && (sent < 4 || q.size() > 0); cyc++) begin
            if (stall < 0 && bus.ValidOut) stall = 2;
            bus.ReadyIn = !(stall > 0);
            if (sent < 4) drive(1'b1, words[sent]);
            else          drive(1'b0, vecs[0]);
            #1;
            if (stalled_prev) check("stall_hold", 32'(out_now()), 32'(snap));
            if (stall > 0) begin
                check("stall_ready", 32'(bus.ReadyOut), 32'd0);
                snap = out_now();
            end
            stalled_prev = (stall > 0);
            if (bus.ValidOut && bus.ReadyIn) begin
                if (q.size() == 0) begin
                    check("stream_extra", 32'(bus.ValidOut), 32'd0);
                end else begin
                    got = q.pop_front();
                    check({"stream_", got.name}, 32'(out_now()), 32'(out_exp(got)));
                end
            end
            if (bus.ValidIn && bus.ReadyOut) begin
                q.push_back(words[sent]);
                sent++;
            end
            if (stall > 0) stall--;
            tick();
        end
        check("stream_drained", 32'((sent == 4) && (q.size() == 0)), 32'd1);
        drive(1'b0, vecs[0]);
        bus.ReadyIn = 1'b1;
        repeat (4) tick();
        check("stream_no_dup", 32'(bus.ValidOut), 32'd0);

        // Reset with three words in flight, then a word right after release.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, vecs[k]);
            tick();
        end
        check("inflight_head", 32'(out_now()), 32'(out_exp(vecs[0])));
        Reset = 1'b0;
        drive(1'b1, vecs[5]);
        tick();
        check("midreset_out", 32'(out_now()), 32'd0);
        check("midreset_ready", 32'(bus.ReadyOut), 32'd1);
        Reset = 1'b1;
        drive(1'b1, vecs[7]);
        tick();
        drive(1'b0, vecs[0]);
        first = 0;
        seen  = 0;
        for (int c = 1; c <= 8; c++) begin
            if (bus.ValidOut) begin
                seen++;
                if (first == 0) begin
                    first = c;
                    check("post_reset_word", 32'(out_now()), 32'(out_exp(vecs[7])));
                end
            end
            tick();
        end
        check("post_reset_latency", 32'(first), 32'd3);
        check("post_reset_count", 32'(seen), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/tanh_deriv.md
TANH_DERIV -- requirements
Module: tanh_deriv

Interface
REQ-001 Parameter FRAC_W, default 24, fractional bits of the internal fixed-point 1 - y^2 datapath.
REQ-002 Clock  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-low; sampled on rising edge of Clock.
REQ-004 ValidIn  input  1  input word valid.
REQ-005 ReadyOut  output  1  block accepts the input word this cycle.
REQ-006 Sign  input  1  sign of activation y.
REQ-007 Exponent  input  5  exponent of y, bias 15 (01111 = 1.0).
REQ-008 Mantissa  input  6  fraction of y, hidden leading 1.
REQ-009 ValidOut  output  1  output word valid.
REQ-010 ReadyIn  input  1  downstream accepts the output word this cycle.
REQ-011 SignOut  output  1  sign of d = 1 - y^2, always 0.
REQ-012 ExponentOut  output  6  exponent of d, bias 31 (011111 = 1.0).
REQ-013 MantissaOut  output  12  fraction of d, hidden leading 1.

Function
REQ-014 The block SHALL compute the tanh derivative d = 1 - y^2 from an activation word in 1/5/6 format and emit it in 1/6/12 format.
REQ-015 All-zero words SHALL encode 0.0 on both sides.
REQ-016 Input transfer SHALL occur when ValidIn and ReadyOut are both 1; output transfer SHALL occur when ValidOut and ReadyIn are both 1.
REQ-017 Global advance enable SHALL be en = ReadyIn OR NOT ValidOut; ReadyOut SHALL equal en combinationally.
REQ-018 Pipeline SHALL have three registered stages (S1 square, S2 subtract, S3 normalize/pack), each carrying a valid bit; all stages advance only when en = 1.
REQ-019 Latency SHALL be exactly 3 cycles from input transfer to ValidOut when ReadyIn stays 1; throughput one word per cycle.
REQ-020 While en = 0, all stage registers and outputs SHALL hold unchanged.
REQ-021 Bubbles SHALL not be compressed; an invalid slot advances like a valid one.
REQ-022 S1: square the 7-bit significand 1.Mantissa to 14 bits, scale by 2^(2*(Exponent-15)), truncate to FRAC_W fractional bits; Sign ignored.
REQ-023 S1: input zero word SHALL yield y^2 = 0; Exponent > 15 or (Exponent = 15 and Mantissa != 0) SHALL clamp y^2 to 1.0.
REQ-024 S2: d_fix = 1.0 - y^2 in unsigned fixed point, FRAC_W fractional bits, no wrap (d_fix >= 0 guaranteed by REQ-023).
REQ-025 S3: d_fix = 0 SHALL output all zeros; d_fix = 1.0 SHALL output ExponentOut 011111, MantissaOut 0.
REQ-026 S3: otherwise, with leading-one position k below the binary point (k = 1..FRAC_W), ExponentOut = 31 - k, MantissaOut = next 12 bits after the leading one, truncated, zero-filled if fewer bits remain.
REQ-027 SignOut SHALL be 0 for every output word.

Reset
REQ-028 While Reset = 0 at a rising edge, all stage valid bits, ValidOut, SignOut, ExponentOut and MantissaOut SHALL become 0.
REQ-029 Reset mid-operation SHALL discard all in-flight words; none emerge after reset release.
REQ-030 During reset ReadyOut SHALL read 1 (ValidOut = 0); inputs presented during reset SHALL be dropped.
REQ-031 First word accepted in the cycle after Reset returns to 1 SHALL appear after 3 cycles.

Structure
REQ-032 Shared package SHALL hold: input bias 15, output bias 31, field widths (5/6 in, 6/12 out), FRAC_W default, ONE_OUT encoding (0/011111/0), ZERO encoding.
REQ-033 Leading-one detection in S3 SHALL be a separate sub-module lzc_frac (FRAC_W-bit leading-zero counter, combinational); all other logic in tanh_deriv.

Verification
REQ-034 y = +0.5 (0/01110/000000), ReadyIn = 1 -> 3 cycles later ValidOut = 1, 0/011110/100000000000 (0.75).
REQ-035 y = -0.75 (1/01110/100000) -> 0/011101/110000000000 (0.4375), SignOut 0.
REQ-036 y = 0 (all zeros) -> 0/011111/0; y = -1.0 (1/01111/000000) -> all zeros; y = 1/10000/000000 -> all zeros (clamp).
REQ-037 Back-to-back 4 words with ReadyIn low for 2 cycles once ValidOut asserts -> ReadyOut low those 2 cycles, outputs held stable, all 4 words delivered in order, none lost or duplicated.
REQ-038 Reset = 0 asserted with 3 words in flight -> next cycle ValidOut = 0, outputs zero; after release no stale word emerges.
REQ-039 y = 0/00001/000000 (2^-14) -> y^2 truncates to 0 at FRAC_W = 24 -> 0/011111/0.
